// File: rtl/pipe_hazard_unit.sv
// Hazard detection and operand-forwarding control for the five-stage miniCPU pipeline.
// Define FORWARD_EN to build the forwarding variant; otherwise the unit is a stall-until-retire interlock.
module pipe_hazard_unit #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              flush,
    output logic              stall,
    output logic              bubble,
    output logic [2:0]        fwd_a,
    output logic [2:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [2:0] FwdRf     = 3'd0;
`ifdef FORWARD_EN
    localparam logic [2:0] FwdExeAlu = 3'd1;
    localparam logic [2:0] FwdMemAlu = 3'd2;
    localparam logic [2:0] FwdMemDo  = 3'd3;
    localparam logic [2:0] FwdWb     = 3'd4;
`endif

    logic              exe_v_q, exe_w_q, exe_m_q;
    logic [REG_AW-1:0] exe_dst_q;
    logic              mem_v_q, mem_w_q, mem_m_q;
    logic [REG_AW-1:0] mem_dst_q;
    logic              wb_v_q, wb_w_q, wb_m_q;
    logic [REG_AW-1:0] wb_dst_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic              src_a, src_b;
    logic              haz_a, haz_b, hazard;
    logic [2:0]        sel_a, sel_b;

    // r0 is hardwired zero, so it never counts as a produced value.
    function automatic logic writes(input logic v, input logic w,
                                    input logic [REG_AW-1:0] d, input logic [REG_AW-1:0] r);
        return v & w & (d == r) & (r != '0);
    endfunction

`ifdef FORWARD_EN
    // Youngest producer wins; a load still in EXE has no data yet.
    function automatic logic [3:0] resolve(input logic src, input logic [REG_AW-1:0] r);
        logic       haz;
        logic [2:0] sel;
        haz = 1'b0;
        sel = FwdRf;
        if (src) begin
            if (writes(exe_v_q, exe_w_q, exe_dst_q, r)) begin
                if (exe_m_q) haz = 1'b1;
                else         sel = FwdExeAlu;
            end else if (writes(mem_v_q, mem_w_q, mem_dst_q, r)) begin
                sel = mem_m_q ? FwdMemDo : FwdMemAlu;
            end else if (writes(wb_v_q, wb_w_q, wb_dst_q, r)) begin
                sel = FwdWb;
            end
        end
        return {haz, sel};
    endfunction
`else
    function automatic logic pending(input logic src, input logic [REG_AW-1:0] r);
        return src & (writes(exe_v_q, exe_w_q, exe_dst_q, r) |
                      writes(mem_v_q, mem_w_q, mem_dst_q, r) |
                      writes(wb_v_q, wb_w_q, wb_dst_q, r));
    endfunction
`endif

    always_comb begin
        src_a = id_valid & id_rs_used & (id_rs != '0);
        src_b = id_valid & id_rt_used & (id_rt != '0);
`ifdef FORWARD_EN
        {haz_a, sel_a} = resolve(src_a, id_rs);
        {haz_b, sel_b} = resolve(src_b, id_rt);
`else
        haz_a = pending(src_a, id_rs);
        haz_b = pending(src_b, id_rt);
        sel_a = FwdRf;
        sel_b = FwdRf;
`endif
        hazard = haz_a | haz_b;
        // Outputs are forced quiet while reset is held so the stall drops immediately.
        stall  = rst_n & hazard & ~flush;
        bubble = rst_n & ((hazard & ~flush) | flush);
        fwd_a  = rst_n ? sel_a : FwdRf;
        fwd_b  = rst_n ? sel_b : FwdRf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exe_v_q     <= 1'b0;
            exe_w_q     <= 1'b0;
            exe_m_q     <= 1'b0;
            exe_dst_q   <= '0;
            mem_v_q     <= 1'b0;
            mem_w_q     <= 1'b0;
            mem_m_q     <= 1'b0;
            mem_dst_q   <= '0;
            wb_v_q      <= 1'b0;
            wb_w_q      <= 1'b0;
            wb_m_q      <= 1'b0;
            wb_dst_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            exe_v_q   <= id_valid & ~stall & ~flush;
            exe_w_q   <= id_wreg;
            exe_m_q   <= id_m2reg;
            exe_dst_q <= id_dst;
            mem_v_q   <= exe_v_q;
            mem_w_q   <= exe_w_q;
            mem_m_q   <= exe_m_q;
            mem_dst_q <= exe_dst_q;
            wb_v_q    <= mem_v_q;
            wb_w_q    <= mem_w_q;
            wb_m_q    <= mem_m_q;
            wb_dst_q  <= mem_dst_q;
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed table-driven bench for pipe_hazard_unit; expectations follow the FORWARD_EN build setting.
module tb_pipe_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_rs_used, id_rt_used, id_wreg, id_m2reg, flush;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        stall, bubble;
    logic [2:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt;

`ifdef FORWARD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    always #5 clk = ~clk;

    pipe_hazard_unit #(.REG_AW(5), .CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .id_wreg    (id_wreg),
        .id_m2reg   (id_m2reg),
        .id_dst     (id_dst),
        .flush      (flush),
        .stall      (stall),
        .bubble     (bubble),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        logic       v;
        logic [4:0] rs, rt;
        logic       ru, tu, w, m;
        logic [4:0] dst;
        logic       fl;
        logic       st, bu;
        logic [2:0] fa, fb;
        int         cnt;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input bit v, input int rs, input int rt, input bit ru,
                                input bit tu, input bit w, input bit m, input int dst,
                                input bit fl, input bit st, input bit bu, input int fa,
                                input int fb, input int cnt);
        vec_t t;
        t.v = v;   t.rs = 5'(rs); t.rt = 5'(rt); t.ru = ru; t.tu = tu;
        t.w = w;   t.m = m;       t.dst = 5'(dst); t.fl = fl;
        t.st = st; t.bu = bu;     t.fa = 3'(fa);   t.fb = 3'(fb); t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid = t.v;   id_rs = t.rs;   id_rt = t.rt;
        id_rs_used = t.ru; id_rt_used = t.tu;
        id_wreg = t.w;    id_m2reg = t.m; id_dst = t.dst; flush = t.fl;
    endtask

    initial begin
        int n;
        vec_t t;

        // Columns: v rs rt ru tu w m dst fl | stall bubble fwd_a fwd_b stall_cnt
`ifdef FORWARD_EN
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 0, 2, 0,   0, 0, 0, 0, 0)); // add r2
        tbl.push_back(mk(1, 2, 1, 1, 1, 1, 0, 3, 0,   0, 0, 1, 0, 0)); // sub r3,r2,r1
        tbl.push_back(mk(1, 2, 0, 1, 1, 1, 0, 4, 0,   0, 0, 2, 0, 0));
        tbl.push_back(mk(1, 2, 2, 1, 1, 1, 0, 5, 0,   0, 0, 4, 4, 0));
        tbl.push_back(mk(1, 2, 6, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 1, 7, 0,   0, 0, 0, 0, 0)); // lw r7
        tbl.push_back(mk(1, 7, 4, 1, 1, 1, 0, 8, 0,   1, 1, 0, 0, 0)); // load-use
        tbl.push_back(mk(1, 7, 4, 1, 1, 1, 0, 8, 0,   0, 0, 3, 0, 1));
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 0, 5, 0,   0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 0, 5, 0,   0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 5, 1, 1, 1, 0, 9, 0,   0, 0, 0, 1, 1)); // double match
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0, 1)); // r0 traffic
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 1, 10, 0,  0, 0, 0, 0, 1)); // lw r10
        tbl.push_back(mk(1, 10, 0, 1, 0, 1, 0, 11, 1, 0, 1, 0, 0, 1)); // flushed hazard
        tbl.push_back(mk(1, 11, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
`else
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 0, 2, 0,   0, 0, 0, 0, 0)); // add r2
        tbl.push_back(mk(1, 2, 1, 1, 1, 1, 0, 3, 0,   1, 1, 0, 0, 0)); // sub r3,r2,r1
        tbl.push_back(mk(1, 2, 1, 1, 1, 1, 0, 3, 0,   1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 2, 1, 1, 1, 1, 0, 3, 0,   1, 1, 0, 0, 2));
        tbl.push_back(mk(1, 2, 1, 1, 1, 1, 0, 3, 0,   0, 0, 0, 0, 3));
        tbl.push_back(mk(1, 2, 0, 1, 1, 1, 0, 4, 0,   0, 0, 0, 0, 3));
        tbl.push_back(mk(1, 2, 2, 1, 1, 1, 0, 5, 0,   0, 0, 0, 0, 3));
        tbl.push_back(mk(1, 2, 6, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 3));
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 1, 7, 0,   0, 0, 0, 0, 3)); // lw r7
        tbl.push_back(mk(1, 7, 4, 1, 1, 1, 0, 8, 0,   1, 1, 0, 0, 3)); // load-use
        tbl.push_back(mk(1, 7, 4, 1, 1, 1, 0, 8, 0,   1, 1, 0, 0, 4));
        tbl.push_back(mk(1, 7, 4, 1, 1, 1, 0, 8, 0,   1, 1, 0, 0, 5));
        tbl.push_back(mk(1, 7, 4, 1, 1, 1, 0, 8, 0,   0, 0, 0, 0, 6));
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 0, 5, 0,   0, 0, 0, 0, 6));
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 0, 5, 0,   0, 0, 0, 0, 6));
        tbl.push_back(mk(1, 0, 5, 1, 1, 1, 0, 9, 0,   1, 1, 0, 0, 6)); // double match
        tbl.push_back(mk(1, 0, 5, 1, 1, 1, 0, 9, 0,   1, 1, 0, 0, 7));
        tbl.push_back(mk(1, 0, 5, 1, 1, 1, 0, 9, 0,   1, 1, 0, 0, 8));
        tbl.push_back(mk(1, 0, 5, 1, 1, 1, 0, 9, 0,   0, 0, 0, 0, 9));
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0, 9)); // r0 traffic
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0, 9));
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 1, 10, 0,  0, 0, 0, 0, 9)); // lw r10
        tbl.push_back(mk(1, 10, 0, 1, 0, 1, 0, 11, 1, 0, 1, 0, 0, 9)); // flushed hazard
        tbl.push_back(mk(1, 11, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 9));
`endif

        // Reset with a live ID instruction: outputs must stay quiet.
        rst_n = 1'b0;
        drive(mk(1, 2, 2, 1, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset stall", stall, 0);
        chk("reset bubble", bubble, 0);
        chk("reset fwd_a", fwd_a, 0);
        chk("reset fwd_b", fwd_b, 0);
        chk("reset stall_cnt", stall_cnt, 0);
        rst_n = 1'b1;
        id_valid = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("row%0d stall", i), stall, tbl[i].st);
            chk($sformatf("row%0d bubble", i), bubble, tbl[i].bu);
            chk($sformatf("row%0d stall_cnt", i), stall_cnt, tbl[i].cnt);
            if (!tbl[i].st && !tbl[i].fl) begin
                chk($sformatf("row%0d fwd_a", i), fwd_a, tbl[i].fa);
                chk($sformatf("row%0d fwd_b", i), fwd_b, tbl[i].fb);
            end
        end

        // Reset asserted in the middle of a load-use stall.
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0)); // lw r2
        @(negedge clk);
        drive(mk(1, 2, 0, 1, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0)); // add r3,r2
        #1;
        chk("midstall stall before reset", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("midstall stall in reset", stall, 0);
        chk("midstall bubble in reset", bubble, 0);
        chk("midstall fwd_a in reset", fwd_a, 0);
        @(negedge clk);
        #1;
        chk("midstall stall_cnt cleared", stall_cnt, 0);
        rst_n = 1'b1;
        #1;
        chk("after reset stall", stall, 0);
        chk("after reset fwd_a", fwd_a, 0);

        // Standalone load-use, counting stall cycles with a bounded wait.
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 1, 1, 12, 0, 0, 0, 0, 0, 0)); // lw r12
        @(negedge clk);
        t = mk(1, 12, 4, 1, 1, 1, 0, 13, 0, 0, 0, 0, 0, 0);
        drive(t);
        #1;
        n = 0;
        while (stall && n < 6) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("load-use stall cycles", n, Fwd ? 1 : 3);
        chk("load-use fwd_a after stall", fwd_a, Fwd ? 3 : 0);
        chk("load-use stall_cnt", stall_cnt, Fwd ? 1 : 3);
        chk("load-use bubble after stall", bubble, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
